// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer: op encodings, FSM states
// and the JK next-state function used by the on-chip model.
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } jk_state_e;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

// File: rtl/jk_cmd_fifo.sv
// Synchronous command FIFO with occupancy count; push is ignored when full and
// pop is ignored when empty. Read data is the current head (show-ahead).
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_level == LW'(DEPTH));
  assign empty     = (r_level == {LW{1'b0}});
  assign level     = r_level;
  assign dout      = r_mem[r_rptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage carries no reset; only pointers and occupancy are control state.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= {AW{1'b0}};
      r_rptr  <= {AW{1'b0}};
      r_level <= {LW{1'b0}};
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Buffers JK commands and replays each onto registered j/k for a programmed
// number of cycles, while tracking the expected flip-flop state against q_fb.
module jk_cmd_sequencer
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [CW-1:0]          cmd_count,
  output logic                   j,
  output logic                   k,
  input  logic                   q_fb,
  output logic                   q_exp,
  output logic                   q_known,
  output logic                   mismatch,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int FW = 2 + CW;

  jk_state_e     r_state;
  logic          r_j;
  logic          r_k;
  logic [CW-1:0] r_remaining;
  logic          r_q_exp;
  logic          r_q_known;
  logic          r_mismatch;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_take;
  logic [FW-1:0] w_head;
  logic [1:0]    w_op;
  logic [CW-1:0] w_cnt;

  assign cmd_ready = ~w_full;
  assign w_push    = cmd_valid & ~w_full;
  assign w_op      = w_head[FW-1:CW];
  assign w_cnt     = w_head[CW-1:0];

  // A new entry is taken whenever the current one has no cycles left,
  // which also covers the back-to-back case without a gap cycle.
  assign w_take = ~w_empty & ((r_state == IDLE) || (r_remaining == {CW{1'b0}}));

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_take),
    .din   ({cmd_op, cmd_count}),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      {r_j, r_k}  <= JK_HOLD;
      r_remaining <= {CW{1'b0}};
      r_q_exp     <= 1'b0;
      r_q_known   <= 1'b0;
      r_mismatch  <= 1'b0;
    end else begin
      // Model advances on the same j/k the flip-flop samples at this edge.
      r_q_exp <= jk_next(r_q_exp, r_j, r_k);
      if (r_j ^ r_k) r_q_known <= 1'b1;
      if (r_q_known && (q_fb != r_q_exp)) r_mismatch <= 1'b1;

      if (w_take) begin
        {r_j, r_k}  <= w_op;
        r_remaining <= (w_cnt == {CW{1'b0}}) ? {CW{1'b0}} : w_cnt - CW'(1);
        r_state     <= ISSUE;
      end else if ((r_state == ISSUE) && (r_remaining != {CW{1'b0}})) begin
        r_remaining <= r_remaining - CW'(1);
      end else begin
        {r_j, r_k}  <= JK_HOLD;
        r_state     <= IDLE;
      end
    end
  end

  assign j        = r_j;
  assign k        = r_k;
  assign q_exp    = r_q_exp;
  assign q_known  = r_q_known;
  assign mismatch = r_mismatch;
  assign busy     = (r_state == ISSUE);

endmodule
